// File: rtl/ddr_port_responder.sv
// Responder side of the DDR user port: a command slot, write/read data FIFOs and an
// on-chip word RAM standing in for the external memory controller.
module ddr_port_responder #(
   parameter int ADDR_W       = 10,
   parameter int WF_DEPTH     = 64,
   parameter int RF_DEPTH     = 64,
   parameter int CALIB_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        calib_done,
   input  logic        cmd_en,
   input  logic [2:0]  cmd_instr,
   input  logic [29:0] cmd_byte_addr,
   input  logic [5:0]  cmd_bl,
   output logic        cmd_full,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_mask,
   output logic        wr_full,
   output logic [6:0]  wr_count,
   input  logic        rd_en,
   output logic [31:0] rd_data,
   output logic        rd_empty,
   output logic [6:0]  rd_count,
   output logic        err
);

   localparam int RAM_DEPTH = 1 << ADDR_W;
   localparam int WF_AW     = $clog2(WF_DEPTH);
   localparam int WF_CW     = $clog2(WF_DEPTH + 1);
   localparam int RF_AW     = $clog2(RF_DEPTH);
   localparam int RF_CW     = $clog2(RF_DEPTH + 1);
   localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);

   localparam logic [2:0] INSTR_WR = 3'b000;
   localparam logic [2:0] INSTR_RD = 3'b001;

   typedef enum logic [2:0] {
      S_CALIB,
      S_IDLE,
      S_WRITE,
      S_RWAIT,
      S_READ,
      S_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [CAL_W-1:0]    calib_cnt;
   logic [ADDR_W-1:0]   burst_addr;
   logic [6:0]          burst_cnt;
   logic                cmd_accept;
   logic                cmd_illegal;
   logic                ram_we;
   logic                ram_re;
   logic                issue_v;
   logic                err_event;
   int                  rf_free;

   // Write FIFO: mask and data travel together as one 36-bit entry.
   logic [35:0]         wf_mem [WF_DEPTH];
   logic [WF_AW-1:0]    wf_wptr, wf_rptr;
   logic [WF_CW-1:0]    wf_count;
   logic                wf_push, wf_pop, wf_empty;
   logic [35:0]         wf_head;

   logic [31:0]         rf_mem [RF_DEPTH];
   logic [RF_AW-1:0]    rf_wptr, rf_rptr;
   logic [RF_CW-1:0]    rf_count;
   logic                rf_push, rf_pop;

   logic [31:0]         ram [RAM_DEPTH];
   logic [31:0]         ram_q;

   // Byte-offset bits and address bits above the RAM are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cmd_byte_addr[29:ADDR_W+2], cmd_byte_addr[1:0]};

   assign calib_done = (state_q != S_CALIB);
   assign cmd_full   = (state_q != S_IDLE);

   assign wf_empty = (wf_count == '0);
   assign wr_full  = (wf_count == WF_CW'(WF_DEPTH));
   assign wr_count = 7'(wf_count);
   assign wf_push  = wr_en && !wr_full;
   assign wf_pop   = ram_we;
   assign wf_head  = wf_mem[wf_rptr];

   assign rd_empty = (rf_count == '0);
   assign rd_count = 7'(rf_count);
   assign rf_push  = issue_v;
   assign rf_pop   = rd_en && !rd_empty;

   // Words already issued to the RAM but not yet in the FIFO still consume space.
   assign rf_free = RF_DEPTH - int'(rf_count) - int'(issue_v);

   assign err_event = (cmd_en && cmd_full) || cmd_illegal ||
                      (wr_en && wr_full) || (rd_en && rd_empty);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      cmd_accept  = 1'b0;
      cmd_illegal = 1'b0;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      case (state_q)
         S_CALIB: begin
            if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (cmd_en) begin
               if (cmd_instr == INSTR_WR) begin
                  cmd_accept = 1'b1;
                  state_d    = S_WRITE;
               end else if (cmd_instr == INSTR_RD) begin
                  cmd_accept = 1'b1;
                  state_d    = S_RWAIT;
               end else begin
                  cmd_illegal = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (!wf_empty) begin
               ram_we = 1'b1;
               if (burst_cnt == 7'd1) state_d = S_IDLE;
            end
         end
         S_RWAIT: begin
            if (rf_free >= int'(burst_cnt)) state_d = S_READ;
         end
         S_READ: begin
            ram_re = 1'b1;
            if (burst_cnt == 7'd1) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_CALIB;
         calib_cnt  <= '0;
         burst_addr <= '0;
         burst_cnt  <= '0;
         issue_v    <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q <= state_d;
         issue_v <= ram_re;
         if (state_q == S_CALIB) calib_cnt <= calib_cnt + 1'b1;
         if (cmd_accept) begin
            burst_addr <= cmd_byte_addr[ADDR_W+1:2];
            burst_cnt  <= {1'b0, cmd_bl} + 7'd1;
         end else if (ram_we || ram_re) begin
            burst_addr <= burst_addr + 1'b1;
            burst_cnt  <= burst_cnt - 1'b1;
         end
         if (err_event) err <= 1'b1;
      end
   end

   // NOTE: storage arrays carry no reset; only pointers and counts define FIFO contents.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (!wf_head[32+b]) ram[burst_addr][8*b +: 8] <= wf_head[8*b +: 8];
         end
      end
      if (ram_re) ram_q <= ram[burst_addr];
   end

   always_ff @(posedge clk) begin
      if (wf_push) wf_mem[wf_wptr] <= {wr_mask, wr_data};
      if (rf_push) rf_mem[rf_wptr] <= ram_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wf_wptr  <= '0;
         wf_rptr  <= '0;
         wf_count <= '0;
      end else begin
         if (wf_push) wf_wptr <= (wf_wptr == WF_AW'(WF_DEPTH - 1)) ? '0 : wf_wptr + 1'b1;
         if (wf_pop)  wf_rptr <= (wf_rptr == WF_AW'(WF_DEPTH - 1)) ? '0 : wf_rptr + 1'b1;
         case ({wf_push, wf_pop})
            2'b10:   wf_count <= wf_count + 1'b1;
            2'b01:   wf_count <= wf_count - 1'b1;
            default: wf_count <= wf_count;
         endcase
      end
   end

   // rd_data is registered and only moves on an accepted pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_wptr  <= '0;
         rf_rptr  <= '0;
         rf_count <= '0;
         rd_data  <= '0;
      end else begin
         if (rf_push) rf_wptr <= (rf_wptr == RF_AW'(RF_DEPTH - 1)) ? '0 : rf_wptr + 1'b1;
         if (rf_pop) begin
            rf_rptr <= (rf_rptr == RF_AW'(RF_DEPTH - 1)) ? '0 : rf_rptr + 1'b1;
            rd_data <= rf_mem[rf_rptr];
         end
         case ({rf_push, rf_pop})
            2'b10:   rf_count <= rf_count + 1'b1;
            2'b01:   rf_count <= rf_count - 1'b1;
            default: rf_count <= rf_count;
         endcase
      end
   end

endmodule
